vcpu32_mem_responder: RTL and testbench

Memory-side responder for the VCPU-32 core's memory request interface. It sits on the far end of the bus that the CPU pipeline stages drive when they issue instruction-fetch and data-access requests. It accepts one request at a time over a valid/ready handshake and inserts a configurable number of wait states. It then performs a big-endian byte, half-word or word read or write on an internal word array and returns the result over a second valid/ready handshake.

---
 rtl/vcpu32_mem_pkg.sv | 16 +
 rtl/vcpu32_mem_lane.sv | 24 ++
 rtl/vcpu32_mem_responder.sv | 98 +++++++++
 tb/tb_vcpu32_mem_responder.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/vcpu32_mem_pkg.sv
// vcpu32_mem_pkg: shared types and helpers for the VCPU-32 memory responder
package vcpu32_mem_pkg;

    typedef logic [1:0] mem_len_t;

    localparam mem_len_t LEN_BYTE = 2'd0;
    localparam mem_len_t LEN_HALF = 2'd1;
    localparam mem_len_t LEN_WORD = 2'd2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;

    function automatic logic is_misaligned(input mem_len_t len, input logic [1:0] adr_lo);
        return (len == LEN_HALF && adr_lo[0]) || (len == LEN_WORD && adr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/vcpu32_mem_lane.sv
// vcpu32_mem_lane: big-endian byte/half/word lane extract and merge for one 32-bit word
module vcpu32_mem_lane
    import vcpu32_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  ofs,
    input  mem_len_t    len,
    input  logic [31:0] wdata,
    output logic [31:0] wword,
    output logic [31:0] rdata
);

    logic [4:0]  sh;
    logic [31:0] mask;

    // offset 0 is the most significant lane, so the shift grows as the offset shrinks
    always_comb begin
        sh    = len == LEN_BYTE ? {~ofs, 3'b000} : len == LEN_HALF ? {~ofs[1], 4'b0000} : 5'd0;
        mask  = len == LEN_BYTE ? 32'h0000_00ff : len == LEN_HALF ? 32'h0000_ffff : 32'hffff_ffff;
        rdata = (word >> sh) & mask;
        wword = (word & ~(mask << sh)) | ((wdata & mask) << sh);
    end

endmodule

// File: rtl/vcpu32_mem_responder.sv
// vcpu32_mem_responder: wait-stated big-endian memory responder for the VCPU-32 request bus
module vcpu32_mem_responder
    import vcpu32_mem_pkg::*;
#(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 2,
    parameter int ADR_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wr,
    input  logic [1:0]       req_len,
    input  logic [ADR_W-1:0] req_adr,
    input  logic [31:0]      req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err
);

    localparam int         AW    = $clog2(MEM_WORDS);
    localparam logic [63:0] LIMIT = 64'(MEM_WORDS) * 64'd4;

    mem_state_t       state, state_nx;
    logic [3:0]       cnt;
    logic             wr_q, a_wr;
    mem_len_t         len_q, a_len;
    logic [ADR_W-1:0] adr_q, a_adr;
    logic [31:0]      wdata_q, a_wdata;
    logic             go, err, last;
    logic [AW-1:0]    idx;
    logic [31:0]      wword, rdata;
    logic [31:0]      mem [MEM_WORDS];

    assign req_ready = state == IDLE && !rst;
    assign rsp_valid = state == RESP;
    assign last      = cnt == 4'(WAIT_STATES - 1);

    // with zero wait states the access happens in the accept cycle, before the latches fill
    assign {a_wr, a_len, a_adr, a_wdata} = state == IDLE ? {req_wr, req_len, req_adr, req_wdata}
                                                         : {wr_q, len_q, adr_q, wdata_q};
    assign idx = a_adr[AW+1:2];
    assign err = a_len == 2'd3 || is_misaligned(a_len, a_adr[1:0]) || 64'(a_adr) >= LIMIT;

    vcpu32_mem_lane u_lane (
        .word  (mem[idx]),
        .ofs   (a_adr[1:0]),
        .len   (a_len),
        .wdata (a_wdata),
        .wword (wword),
        .rdata (rdata)
    );

    always_comb begin
        state_nx = state;
        go       = 1'b0;
        case (state)
            IDLE: if (req_valid) begin
                state_nx = WAIT_STATES == 0 ? RESP : WAIT;
                go       = WAIT_STATES == 0;
            end
            WAIT: if (last) begin
                state_nx = RESP;
                go       = 1'b1;
            end
            RESP: if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= state == WAIT && !last ? cnt + 4'd1 : '0;
            if (go) begin
                rsp_rdata <= err || a_wr ? '0 : rdata;
                rsp_err   <= err;
            end else if (state == RESP && rsp_ready) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk)
        if (state == IDLE && req_valid) {wr_q, len_q, adr_q, wdata_q} <= {req_wr, req_len, req_adr, req_wdata};

    always_ff @(posedge clk)
        if (go && a_wr && !err && !rst) mem[idx] <= wword;

endmodule

// File: tb/tb_vcpu32_mem_responder.sv
// tb_vcpu32_mem_responder: directed checks of the responder with 2 and 0 wait states
module tb_vcpu32_mem_responder;
    import vcpu32_mem_pkg::*;

    localparam int WS = 2;

    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_wr = 1'b0, rsp_ready = 1'b0;
    logic [1:0]  req_len = 2'd0;
    logic [31:0] req_adr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        z_req_valid = 1'b0, z_req_wr = 1'b0, z_rsp_ready = 1'b0;
    logic [1:0]  z_req_len = 2'd0;
    logic [31:0] z_req_adr = '0, z_req_wdata = '0;
    logic        z_req_ready, z_rsp_valid, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    vcpu32_mem_responder #(.MEM_WORDS(1024), .WAIT_STATES(WS), .ADR_W(32)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_len(req_len),
        .req_adr(req_adr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    vcpu32_mem_responder #(.MEM_WORDS(1024), .WAIT_STATES(0), .ADR_W(32)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_wr(z_req_wr), .req_len(z_req_len),
        .req_adr(z_req_adr), .req_wdata(z_req_wdata),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // one full request/response; hold keeps rsp_ready low for that many cycles in RESP
    task automatic xfer(input string tag, input logic wr, input logic [1:0] len, input logic [31:0] adr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err, input int hold);
        int n, lat;
        @(negedge clk);
        req_valid = 1'b1; req_wr = wr; req_len = len; req_adr = adr; req_wdata = wdata; rsp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(WS + 1));
        chk({tag, " rdata"}, rsp_rdata, exp_rd);
        chk({tag, " err"}, 32'(rsp_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, " hold valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, " hold rdata"}, rsp_rdata, exp_rd);
            chk({tag, " hold ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, " after valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, " after ready"}, 32'(req_ready), 32'd1);
        chk({tag, " after rdata"}, rsp_rdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle req_ready", 32'(req_ready), 32'd1);

        xfer("wr word",      1'b1, LEN_WORD, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 0);
        xfer("rd word",      1'b0, LEN_WORD, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0, 0);
        xfer("wr byte",      1'b1, LEN_BYTE, 32'h11,   32'hAABBCC55, 32'h0,        1'b0, 0);
        xfer("rd merged",    1'b0, LEN_WORD, 32'h10,   32'h0,        32'hDE55BEEF, 1'b0, 0);
        xfer("rd half2",     1'b0, LEN_HALF, 32'h12,   32'h0,        32'h0000BEEF, 1'b0, 0);
        xfer("rd byte0",     1'b0, LEN_BYTE, 32'h10,   32'h0,        32'h000000DE, 1'b0, 0);
        xfer("rd byte3",     1'b0, LEN_BYTE, 32'h13,   32'h0,        32'h000000EF, 1'b0, 0);
        xfer("wr half0",     1'b1, LEN_HALF, 32'h10,   32'h99991234, 32'h0,        1'b0, 0);
        xfer("rd half merge",1'b0, LEN_WORD, 32'h10,   32'h0,        32'h1234BEEF, 1'b0, 0);
        xfer("wr word0",     1'b1, LEN_WORD, 32'h0,    32'h0BADF00D, 32'h0,        1'b0, 0);
        xfer("err half mis", 1'b0, LEN_HALF, 32'h13,   32'h0,        32'h0,        1'b1, 0);
        xfer("err wr oor",   1'b1, LEN_WORD, 32'h1002, 32'hFFFFFFFF, 32'h0,        1'b1, 0);
        xfer("err wr mis",   1'b1, LEN_WORD, 32'h12,   32'hFFFFFFFF, 32'h0,        1'b1, 0);
        xfer("err rd oor",   1'b0, LEN_WORD, 32'h1000, 32'h0,        32'h0,        1'b1, 0);
        xfer("err len3",     1'b0, 2'd3,     32'h10,   32'h0,        32'h0,        1'b1, 0);
        xfer("keep word0",   1'b0, LEN_WORD, 32'h0,    32'h0,        32'h0BADF00D, 1'b0, 0);
        xfer("keep word4",   1'b0, LEN_WORD, 32'h10,   32'h0,        32'h1234BEEF, 1'b0, 0);
        xfer("backpressure", 1'b0, LEN_WORD, 32'h10,   32'h0,        32'h1234BEEF, 1'b0, 5);
        xfer("wr 0x20",      1'b1, LEN_WORD, 32'h20,   32'hA5A5A5A5, 32'h0,        1'b0, 0);

        // abort a write one cycle before its access edge
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b1; req_len = LEN_WORD; req_adr = 32'h20; req_wdata = 32'h12345678;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort wait ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort req_ready", 32'(req_ready), 32'd0);
        chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort rsp_rdata", rsp_rdata, 32'd0);
        chk("abort rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort idle ready", 32'(req_ready), 32'd1);
        xfer("rd after abort", 1'b0, LEN_WORD, 32'h20, 32'h0, 32'hA5A5A5A5, 1'b0, 0);

        // zero-wait-state instance streaming writes with rsp_ready held high
        @(negedge clk);
        z_req_wr = 1'b1; z_req_len = LEN_WORD; z_req_adr = 32'h40; z_req_wdata = 32'hC0FFEE11;
        z_rsp_ready = 1'b1; z_req_valid = 1'b1;
        chk("ws0 first ready", 32'(z_req_ready), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("ws0 rsp_valid", 32'(z_rsp_valid), 32'(i % 2 == 0));
            chk("ws0 req_ready", 32'(z_req_ready), 32'(i % 2 == 1));
        end
        z_req_valid = 1'b0;
        @(negedge clk);
        z_req_wr = 1'b0; z_req_valid = 1'b1;
        @(negedge clk);
        z_req_valid = 1'b0;
        chk("ws0 rd valid", 32'(z_rsp_valid), 32'd1);
        chk("ws0 rd rdata", z_rsp_rdata, 32'hC0FFEE11);
        chk("ws0 rd err", 32'(z_rsp_err), 32'd0);
        @(negedge clk);
        chk("ws0 idle valid", 32'(z_rsp_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
